// File: rtl/rip_branch_resolver.sv
// Carries fetch-time prediction metadata to EX and resolves it; update/redirect registered 1 cycle after resolve.
// i_stall freezes all slots and suppresses outputs; define BP_STATS_EN for branch/mispredict counters.
module rip_branch_resolver #(
   parameter int PIPE_DEPTH = 2,
   parameter int INDEX_W    = 10,
   parameter int WEIGHT_W   = 2
`ifdef BP_STATS_EN
   ,parameter int STAT_WIDTH = 32
`endif
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_stall,
   input  logic                i_flush,
   input  logic                i_cap_valid,
   input  logic [31:0]         i_cap_pc,
   input  logic [INDEX_W-1:0]  i_cap_index,
   input  logic [WEIGHT_W-1:0] i_cap_weight,
   input  logic                i_cap_pred,
   input  logic                i_ex_is_branch,
   input  logic                i_ex_taken,
   input  logic [31:0]         i_ex_target,
   output logic                o_update,
   output logic [INDEX_W-1:0]  o_update_index,
   output logic [WEIGHT_W-1:0] o_update_weight,
   output logic                o_actual,
   output logic                o_redirect,
   output logic [31:0]         o_redirect_pc
`ifdef BP_STATS_EN
   ,output logic [STAT_WIDTH-1:0] o_stat_branches
   ,output logic [STAT_WIDTH-1:0] o_stat_mispredicts
`endif
);

   typedef struct packed {
      logic                vld;
      logic [31:0]         pc;
      logic [INDEX_W-1:0]  idx;
      logic [WEIGHT_W-1:0] wgt;
      logic                pred;
   } slot_t;

   slot_t               r_slot [PIPE_DEPTH];
   logic                r_update;
   logic [INDEX_W-1:0]  r_update_index;
   logic [WEIGHT_W-1:0] r_update_weight;
   logic                r_actual;
   logic                r_redirect;
   logic [31:0]         r_redirect_pc;

   slot_t               w_ex;
   logic                w_kill;
   logic                w_resolve;
   logic                w_mispredict;

   assign w_ex         = r_slot[PIPE_DEPTH-1];
   // A redirect kills everything younger, including the instruction captured while it was detected.
   assign w_kill       = i_flush | r_redirect;
   assign w_resolve    = w_ex.vld & i_ex_is_branch & ~i_stall & ~w_kill;
   assign w_mispredict = w_resolve & (w_ex.pred != i_ex_taken);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         for (int i = 0; i < PIPE_DEPTH; i++) r_slot[i] <= '0;
      end else if (w_kill) begin
         for (int i = 0; i < PIPE_DEPTH; i++) r_slot[i].vld <= 1'b0;
      end else if (!i_stall) begin
         r_slot[0].vld  <= i_cap_valid;
         r_slot[0].pc   <= i_cap_pc;
         r_slot[0].idx  <= i_cap_index;
         r_slot[0].wgt  <= i_cap_weight;
         r_slot[0].pred <= i_cap_pred;
         for (int i = 1; i < PIPE_DEPTH; i++) r_slot[i] <= r_slot[i-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_update        <= 1'b0;
         r_update_index  <= '0;
         r_update_weight <= '0;
         r_actual        <= 1'b0;
         r_redirect      <= 1'b0;
         r_redirect_pc   <= '0;
      end else begin
         r_update   <= w_resolve;
         r_redirect <= w_mispredict;
         if (w_resolve) begin
            r_update_index  <= w_ex.idx;
            r_update_weight <= w_ex.wgt;
            r_actual        <= i_ex_taken;
         end
         if (w_mispredict) begin
            r_redirect_pc <= i_ex_taken ? i_ex_target : (w_ex.pc + 32'd4);
         end
      end
   end

   assign o_update        = r_update;
   assign o_update_index  = r_update_index;
   assign o_update_weight = r_update_weight;
   assign o_actual        = r_actual;
   assign o_redirect      = r_redirect;
   assign o_redirect_pc   = r_redirect_pc;

`ifdef BP_STATS_EN
   logic [STAT_WIDTH-1:0] r_stat_br;
   logic [STAT_WIDTH-1:0] r_stat_mp;

   // Saturating so long runs never wrap back to small values.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else begin
         if (w_resolve && !(&r_stat_br))    r_stat_br <= r_stat_br + STAT_WIDTH'(1);
         if (w_mispredict && !(&r_stat_mp)) r_stat_mp <= r_stat_mp + STAT_WIDTH'(1);
      end
   end

   assign o_stat_branches    = r_stat_br;
   assign o_stat_mispredicts = r_stat_mp;
`endif

endmodule

// File: tb/tb_rip_branch_resolver.sv
// Directed bench for rip_branch_resolver: per-cycle expected outputs go through a scoreboard queue.
module tb_rip_branch_resolver;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   logic        clk, rstn, stall, flush;
   logic        cap_valid, cap_pred, ex_is_branch, ex_taken;
   logic [31:0] cap_pc, ex_target, redirect_pc;
   logic [9:0]  cap_index, update_index;
   logic [1:0]  cap_weight, update_weight;
   logic        update, actual, redirect;
`ifdef BP_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
   int          exp_br = 0;
   int          exp_mp = 0;
`endif

   typedef struct packed {
      logic        upd;
      logic [9:0]  idx;
      logic [1:0]  wgt;
      logic        act;
      logic        red;
      logic [31:0] rpc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   rip_branch_resolver dut (
      .i_clk(clk), .i_rstn(rstn), .i_stall(stall), .i_flush(flush),
      .i_cap_valid(cap_valid), .i_cap_pc(cap_pc), .i_cap_index(cap_index),
      .i_cap_weight(cap_weight), .i_cap_pred(cap_pred),
      .i_ex_is_branch(ex_is_branch), .i_ex_taken(ex_taken), .i_ex_target(ex_target),
      .o_update(update), .o_update_index(update_index), .o_update_weight(update_weight),
      .o_actual(actual), .o_redirect(redirect), .o_redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
      ,.o_stat_branches(stat_branches), .o_stat_mispredicts(stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic cv, input logic [31:0] pc, input logic [9:0] idx,
                        input logic [1:0] wgt, input logic pred, input logic br,
                        input logic tk, input logic [31:0] tgt, input logic st, input logic fl);
      cap_valid = cv; cap_pc = pc; cap_index = idx; cap_weight = wgt; cap_pred = pred;
      ex_is_branch = br; ex_taken = tk; ex_target = tgt; stall = st; flush = fl;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   // Expected outputs for the edge that ends the cycle whose inputs are currently driven.
   task automatic step(input logic eu, input logic [9:0] eidx, input logic [1:0] ewgt,
                       input logic eact, input logic er, input logic [31:0] erpc);
      exp_t n;
      exp_t e;
      n.upd = eu; n.idx = eidx; n.wgt = ewgt; n.act = eact; n.red = er; n.rpc = erpc;
      sb.push_back(n);
`ifdef BP_STATS_EN
      if (!rstn) begin
         exp_br = 0;
         exp_mp = 0;
      end else begin
         if (eu) exp_br++;
         if (er) exp_mp++;
      end
`endif
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("update", 32'(update), 32'(e.upd));
      chk("redirect", 32'(redirect), 32'(e.red));
      if (e.upd) begin
         chk("update_index", 32'(update_index), 32'(e.idx));
         chk("update_weight", 32'(update_weight), 32'(e.wgt));
         chk("actual", 32'(actual), 32'(e.act));
      end
      if (e.red) chk("redirect_pc", redirect_pc, e.rpc);
`ifdef BP_STATS_EN
      chk("stat_branches", stat_branches, 32'(exp_br));
      chk("stat_mispredicts", stat_mispredicts, 32'(exp_mp));
`endif
   endtask

   task automatic nothing();
      step(1'b0, 10'h0, 2'b00, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_update_index", 32'(update_index), 32'h0);
      chk("rst_update_weight", 32'(update_weight), 32'h0);
      chk("rst_actual", 32'(actual), 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
   endtask

   initial begin
      // Reset, then branches in EX with empty slots must not resolve.
      rstn = 1'b0;
      idle();
      nothing();
      nothing();
      chk_reset_vals();
      rstn = 1'b1;
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
      nothing();
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0);
      nothing();

      // Correct taken prediction.
      drive(1'b1, 32'h100, 10'd5, WT, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nothing();
      idle();
      nothing();
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h180, 1'b0, 1'b0);
      step(1'b1, 10'd5, WT, 1'b1, 1'b0, 32'h0);
      idle();
      nothing();

      // Taken mispredict; younger slots (incl. one captured in the detect cycle) are killed.
      drive(1'b1, 32'h200, 10'd7, WNT, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nothing();
      drive(1'b1, 32'h204, 10'd8, WNT, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nothing();
      drive(1'b1, 32'h208, 10'd9, ST, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
      step(1'b1, 10'd7, WNT, 1'b1, 1'b1, 32'h400);
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      nothing();
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      nothing();

      // Not-taken mispredict at the top of the address space wraps to zero.
      drive(1'b1, 32'hFFFF_FFFC, 10'd3, ST, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nothing();
      idle();
      nothing();
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b0);
      step(1'b1, 10'd3, ST, 1'b0, 1'b1, 32'h0000_0000);
      idle();
      nothing();

      // Stall with branch in EX: nothing during stall, captures ignored, one update after.
      drive(1'b1, 32'h300, 10'd9, SNT, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nothing();
      idle();
      nothing();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h3A0, 10'h3AA, ST, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
         nothing();
      end
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 10'd9, SNT, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      nothing();

      // Flush coincident with a resolving mispredict wins and empties all slots.
      drive(1'b1, 32'h500, 10'd11, WT, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nothing();
      drive(1'b1, 32'h504, 10'd12, WT, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nothing();
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      nothing();
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      nothing();
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      nothing();

      // Reset right after a mispredict drops the pending pulses and clears outputs.
      drive(1'b1, 32'h600, 10'd13, WT, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nothing();
      idle();
      nothing();
      drive(1'b0, 32'h0, 10'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h999, 1'b0, 1'b0);
      step(1'b1, 10'd13, WT, 1'b0, 1'b1, 32'h604);
      rstn = 1'b0;
      idle();
      nothing();
      chk_reset_vals();
      rstn = 1'b1;
      nothing();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
